// File: rtl/mul_feed_pkg.sv
// Shared types and default sizing for the mul1 feeder.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mul_feed_pkg;

  localparam int DEF_SIZE  = 8;
  localparam int DEF_DEPTH = 4;
  localparam int PTR_W     = $clog2(DEF_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    HOLD
  } state_t;

endpackage

// File: rtl/mul_feed_fifo.sv
// Synchronous operand FIFO with registered full/empty derived from an occupancy count.
// Latency: a pushed word is visible on dout the cycle after the push edge; dout is head-of-queue (show-ahead).
// Backpressure: pushes while full and pops while empty are ignored; caller gates with full/empty.
//
// Ports: clk, rst_n (async active-low), push/din, pop/dout, full, empty.
module mul_feed_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // Storage carries no reset: contents are only observed behind a non-zero count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mul_seq_feeder.sv
// Sequences queued operand pairs one at a time into the un-reset repeated-add multiplier mul1.
// Latency: accept edge E0, pop E1, multiplier load E2, result written E(3+b), out_valid after E(4+b).
// Backpressure: in_ready = FIFO not full (registered); a held product (out_valid && !out_ready) stalls the sequencer.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_a/in_b operand input;
//        mul_load/mul_a/mul_b/mul_result multiplier interface; out_valid/out_ready/out_product; busy.
// Optional: define MUL_FEED_ZERO_BYPASS_EN to short-circuit jobs with a zero operand to a product of 0
//           (out_valid one edge after the pop edge, multiplier not loaded).
module mul_seq_feeder
  import mul_feed_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_a,
  input  logic [SIZE-1:0]   in_b,
  output logic              mul_load,
  output logic [SIZE-1:0]   mul_a,
  output logic [SIZE-1:0]   mul_b,
  input  logic [2*SIZE-1:0] mul_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] out_product,
  output logic              busy
);

  state_t              state;
  state_t              state_nxt;
  logic [SIZE-1:0]     cnt;
  logic                zero_job;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [2*SIZE-1:0]   fifo_dout;
  logic [SIZE-1:0]     a_pop;
  logic [SIZE-1:0]     b_pop;
  logic                zero_pop;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign a_pop     = fifo_dout[2*SIZE-1:SIZE];
  assign b_pop     = fifo_dout[SIZE-1:0];
  assign busy      = (state != IDLE) || !fifo_empty;

`ifdef MUL_FEED_ZERO_BYPASS_EN
  assign zero_pop = (a_pop == '0) || (b_pop == '0);
`else
  assign zero_pop = 1'b0;
`endif

  mul_feed_fifo #(
    .W     (2*SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({in_a, in_b}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = zero_pop ? CAPTURE : LOAD;
        end
      end
      LOAD:    state_nxt = RUN;
      // The cnt==0 edge is the multiplier's result-write edge, so RUN spans b+1 edges.
      RUN:     if (cnt == '0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mul_load is registered from the next state so it is low for exactly the LOAD cycle and
  // stays low throughout reset, which re-initialises the multiplier's own state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_load    <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      cnt         <= '0;
      zero_job    <= 1'b0;
      out_valid   <= 1'b0;
      out_product <= '0;
    end else begin
      mul_load <= (state_nxt != LOAD);
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            zero_job <= zero_pop;
            if (!zero_pop) begin
              mul_a <= a_pop;
              mul_b <= b_pop;
              cnt   <= b_pop;
            end
          end
        end
        RUN: begin
          if (cnt != '0) cnt <= cnt - SIZE'(1);
        end
        CAPTURE: begin
          out_product <= zero_job ? '0 : mul_result;
          out_valid   <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
